rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file (x0 hardwired zero, 2 read / 1 write) between NUM_REQ writeback requesters, e.g. ALU and load unit.
- Round-robin arbitration; the winner is registered onto w_en/w_addr/w_data, which connect directly to regfile.
- Keeps a per-register busy scoreboard: a register is reserved at issue and cleared when its writeback is driven to the regfile.

Parameters:
- NUM_REQ, 2, number of writeback requesters (2..4)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  input  1  clock, all state on posedge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester writeback valid
- req_ready  output  NUM_REQ  per-requester accept, combinational one-hot grant
- req_addr  input  NUM_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed writeback data
- rsv_valid  input  1  issue stage reserves a destination register
- rsv_addr  input  ADDR_W  register being reserved
- w_en  output  1  regfile write enable, registered
- w_addr  output  ADDR_W  regfile write address, registered
- w_data  output  DATA_W  regfile write data, registered
- busy  output  2**ADDR_W  scoreboard, bit r=1 means register r has a pending write
- spurious_wb  output  1  sticky error: writeback to a non-busy register

Behaviour:
- Reset (async, rst_n=0): w_en=0, w_addr=0, w_data=0, busy=0, spurious_wb=0, rr pointer=0 (requester 0 highest priority). All outputs stay at these values while rst_n=0. Releasing reset mid-stream discards any in-flight grant.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. A requester holds valid, addr and data stable until accepted. Valid must not depend on ready.
- Arbitration: each cycle at most one req_ready bit is set. The search starts at the rr pointer, takes the first valid requester and wraps modulo NUM_REQ. If no requester is valid, ready=0.
- Pointer update: after a grant to i, pointer = (i+1) mod NUM_REQ. With no grant the pointer holds.
- Latency: a request accepted in cycle N appears on w_en/w_addr/w_data in cycle N+1 (posedge after acceptance). The regfile then commits it at the following posedge.
- No-grant cycle: w_en=0 next cycle; w_addr and w_data hold their last values.
- x0 writes: a request with addr 0 is accepted (ready=1), but next-cycle w_en=0 and busy and spurious_wb are untouched.
- Scoreboard set: rsv_valid with rsv_addr!=0 sets busy[rsv_addr] at posedge. Reserving x0 is ignored. Reserving an already-busy register leaves it busy (no count, single outstanding write per register).
- Scoreboard clear: busy[w_addr] is cleared at the posedge where w_en=1. This is the same edge at which the regfile writes.
- Set and clear of the same register at the same edge: the set wins and busy stays 1.
- Spurious writeback: a request accepted for a nonzero addr whose busy bit is 0 at acceptance sets spurious_wb=1, which holds until reset. The write is still performed.
- Throughput: one writeback per cycle sustained. A requester held valid waits at most NUM_REQ-1 cycles for a grant.

Optional Feature:
- Macro: RF_WB_ARB_STATS_EN.
- Defined: adds output stall_cnt (NUM_REQ*16). Per requester, a 16-bit saturating counter increments each cycle that req_valid[i]=1 and req_ready[i]=0. It holds at 16'hFFFF and resets to 0.
- Undefined: no port and no counters; all other behaviour identical.

Decomposition:
- Package rf_pkg:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_DEPTH=32
  - typedefs rf_addr_t, rf_data_t
  - struct wb_req_t {addr, data}
- Sub-module rr_arbiter (NUM_REQ):
  - combinational one-hot grant from the request vector and pointer, plus the pointer register
  - reusable for future read-port sharing

Test Plan:
- Reset then idle: rst_n low 3 cycles mid-run with req_valid=2'b11 -> w_en=0, busy=0, req_ready=0 during reset. After release, requester 0 is granted first.
- Round-robin fairness: both valid continuously, req0 addr 5 data 32'hA5A5_0001, req1 addr 6 data 32'h5A5A_0002 -> w_addr alternates 5,6,5,6 with w_en=1 every cycle, one cycle after each ready.
- Scoreboard: reserve x7, then a writeback to x7 accepted at cycle N -> busy[7]=1 until the posedge ending cycle N+1, then 0. spurious_wb stays 0.
- Set/clear collision: w_en=1 to x9 in the same cycle as rsv_valid to x9 -> busy[9]=1 after the edge.
- x0 handling: reserve x0 and writeback x0 data 32'hFFFF_FFFF -> ready=1, w_en=0 next cycle, busy[0]=0, spurious_wb=0. Regfile read of x0 returns 0.
- Spurious writeback: writeback x12 with busy[12]=0 -> spurious_wb=1 and w_en=1 to x12; the flag persists until rst_n is asserted.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register-file widths and writeback request type
package rf_pkg;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with its rotating priority pointer
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               gnt_any
);
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;

    // Scan from the pointer upward, wrapping, and stop at the first requester.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        gnt_any = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (en && !gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - regfile write-port arbiter with busy scoreboard; RF_WB_ARB_STATS_EN adds stall counters
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W,
    localparam int DEPTH  = 1 << ADDR_W,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic                      w_en,
    output logic [ADDR_W-1:0]         w_addr,
    output logic [DATA_W-1:0]         w_data,
    output logic [DEPTH-1:0]          busy,
    output logic                      spurious_wb
`ifdef RF_WB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stall_cnt
`endif
);
    logic [PTR_W-1:0]  gnt_idx;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [DEPTH-1:0]  busy_nxt;

    // Grants are suppressed while reset is held so ready stays low.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rst_n),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .gnt_any (accept)
    );

    assign sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            w_en <= accept && (sel_addr != '0);
            if (accept) begin
                w_addr <= sel_addr;
                w_data <= sel_data;
            end
        end
    end

    // Clear first, then set, so a same-edge reservation keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (w_en) begin
            busy_nxt[w_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= '0;
            spurious_wb <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (accept && (sel_addr != '0) && !busy[sel_addr]) begin
                spurious_wb <= 1'b1;
            end
        end
    end

`ifdef RF_WB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_ready[i] && (stall_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with directed and random traffic
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int N = 2;

    typedef struct packed {
        logic                en;
        rf_addr_t            addr;
        rf_data_t            data;
        logic [RF_DEPTH-1:0] busy;
        logic                spur;
    } exp_t;

    logic                   clk_tb = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           req_valid;
    logic [N-1:0]           req_ready;
    logic [N*RF_ADDR_W-1:0] req_addr;
    logic [N*RF_DATA_W-1:0] req_data;
    logic                   rsv_valid;
    rf_addr_t               rsv_addr;
    logic                   w_en;
    rf_addr_t               w_addr;
    rf_data_t               w_data;
    logic [RF_DEPTH-1:0]    busy;
    logic                   spurious_wb;
`ifdef RF_WB_ARB_STATS_EN
    logic [N*16-1:0]        stall_cnt;
`endif

    rf_wb_arbiter #(.NUM_REQ(N), .ADDR_W(RF_ADDR_W), .DATA_W(RF_DATA_W)) dut (
        .clk         (clk_tb),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rsv_valid   (rsv_valid),
        .rsv_addr    (rsv_addr),
        .w_en        (w_en),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .busy        (busy),
        .spurious_wb (spurious_wb)
`ifdef RF_WB_ARB_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk_tb = ~clk_tb;

    // Stimulus-side state: what each requester is presenting
    logic [N-1:0] t_valid;
    wb_req_t      t_req [N];
    logic         t_rsv;
    rf_addr_t     t_rsv_addr;
    logic         t_rstn;

    // Reference model state
    int                  m_ptr;
    logic                m_wen;
    rf_addr_t            m_waddr;
    rf_data_t            m_wdata;
    logic [RF_DEPTH-1:0] m_busy;
    logic                m_spur;

    logic [N-1:0] rdy_q [$];
    exp_t         out_q [$];
    logic         done = 1'b0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic set_req(input int i, input rf_addr_t a, input rf_data_t d);
        t_valid[i]     = 1'b1;
        t_req[i].addr  = a;
        t_req[i].data  = d;
    endtask

    // One clock: drive inputs at the falling edge, predict ready now and outputs after the next rise.
    task automatic tick();
        int                  g;
        int                  idx;
        logic [N-1:0]        oh;
        logic [RF_DEPTH-1:0] nb;
        exp_t                e;
        @(negedge clk_tb);
        rst_n     = t_rstn;
        req_valid = t_valid;
        for (int i = 0; i < N; i++) begin
            req_addr[i*RF_ADDR_W +: RF_ADDR_W] = t_req[i].addr;
            req_data[i*RF_DATA_W +: RF_DATA_W] = t_req[i].data;
        end
        rsv_valid = t_rsv;
        rsv_addr  = t_rsv_addr;

        g = -1;
        if (t_rstn) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && t_valid[idx]) g = idx;
            end
        end
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        rdy_q.push_back(oh);

        if (!t_rstn) begin
            m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_spur = 1'b0;
        end else begin
            nb = m_busy;
            if (m_wen) nb[m_waddr] = 1'b0;
            if (t_rsv && t_rsv_addr != '0) nb[t_rsv_addr] = 1'b1;
            if (g >= 0) begin
                if (t_req[g].addr != '0 && !m_busy[t_req[g].addr]) m_spur = 1'b1;
                m_wen   = (t_req[g].addr != '0);
                m_waddr = t_req[g].addr;
                m_wdata = t_req[g].data;
                m_ptr   = (g + 1) % N;
            end else begin
                m_wen = 1'b0;
            end
            m_busy = nb;
        end
        e.en = m_wen; e.addr = m_waddr; e.data = m_wdata; e.busy = m_busy; e.spur = m_spur;
        out_q.push_back(e);
        if (g >= 0) t_valid[g] = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the only process that compares and counts
    initial begin
        logic [N-1:0] er;
        exp_t         eo;
        while (!done) begin
            @(negedge clk_tb);
            #2;
            if (rdy_q.size() > 0) begin
                er = rdy_q.pop_front();
                check("req_ready", 64'(req_ready), 64'(er));
            end
            @(posedge clk_tb);
            #1;
            if (out_q.size() > 0) begin
                eo = out_q.pop_front();
                check("w_en", 64'(w_en), 64'(eo.en));
                if (eo.en) begin
                    check("w_addr", 64'(w_addr), 64'(eo.addr));
                    check("w_data", 64'(w_data), 64'(eo.data));
                end
                check("busy", 64'(busy), 64'(eo.busy));
                check("spurious_wb", 64'(spurious_wb), 64'(eo.spur));
            end
        end
        check("queues_drained", 64'(rdy_q.size() + out_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; rsv_valid = 1'b0; rsv_addr = '0;
        t_rstn = 1'b0; t_valid = '0; t_rsv = 1'b0; t_rsv_addr = '0;
        for (int i = 0; i < N; i++) t_req[i] = '0;
        m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_busy = '0; m_spur = 1'b0;

        // Reset with both requesters pending to x0; requester 0 wins first after release
        set_req(0, 5'd0, 32'h1111_0000);
        set_req(1, 5'd0, 32'h2222_0000);
        repeat (3) tick();
        t_rstn = 1'b1;
        tick();
        tick();

        // Reserve x7, then write it back
        t_rsv = 1'b1; t_rsv_addr = 5'd7;
        tick();
        t_rsv = 1'b0;
        set_req(0, 5'd7, 32'hC0DE_0007);
        repeat (3) tick();

        // Reservation of x9 at the same edge that writes x9
        t_rsv = 1'b1; t_rsv_addr = 5'd9;
        tick();
        t_rsv = 1'b0;
        set_req(1, 5'd9, 32'hC0DE_0009);
        tick();
        t_rsv = 1'b1; t_rsv_addr = 5'd9;
        tick();
        t_rsv = 1'b0;
        tick();

        // Reserve and write x0
        t_rsv = 1'b1; t_rsv_addr = 5'd0;
        set_req(0, 5'd0, 32'hFFFF_FFFF);
        tick();
        t_rsv = 1'b0;
        tick();

        // Round-robin with both requesters always valid
        for (int c = 0; c < 8; c++) begin
            set_req(0, 5'd5, 32'hA5A5_0001);
            set_req(1, 5'd6, 32'h5A5A_0002);
            tick();
        end

        // Mid-run reset with both valid
        set_req(0, 5'd0, 32'h0);
        set_req(1, 5'd0, 32'h0);
        t_rstn = 1'b0;
        repeat (3) tick();
        t_rstn = 1'b1;
        tick();
        tick();

        // Spurious writeback to x12; flag sticks until reset
        set_req(1, 5'd12, 32'hBAD0_000C);
        repeat (4) tick();
        t_rstn = 1'b0;
        tick();
        t_rstn = 1'b1;
        tick();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!t_valid[i] && $urandom_range(0, 9) < 6) begin
                    set_req(i, rf_addr_t'($urandom_range(0, 15)), rf_data_t'($urandom));
                end
            end
            t_rsv      = ($urandom_range(0, 9) < 4);
            t_rsv_addr = rf_addr_t'($urandom_range(0, 15));
            t_rstn     = ($urandom_range(0, 49) != 0);
            tick();
        end
        t_valid = '0; t_rsv = 1'b0; t_rstn = 1'b1;
        repeat (2) @(posedge clk_tb);
        done = 1'b1;
    end
endmodule
